// File: rtl/idli_sdecode_m_if.sv
// Beat/op bundle for idli_sdecode_m: instruction beats in, decoded op record out.
// o_sdc_dbg_state mirrors the collector state (0 INSN, 1 IMM, 2 HOLD) for checkers.
interface idli_sdecode_m_if #(
  parameter int LANE_W = 4,
  parameter int IMM_W  = 16
);
  logic              i_sdc_flush;
  logic [LANE_W-1:0] i_sdc_enc;
  logic              i_sdc_enc_vld;
  logic              o_sdc_enc_rdy;
  logic              o_sdc_op_vld;
  logic              i_sdc_op_rdy;
  logic [4:0]        o_sdc_opc;
  logic [1:0]        o_sdc_p;
  logic [2:0]        o_sdc_a;
  logic [1:0]        o_sdc_q;
  logic [2:0]        o_sdc_b;
  logic [2:0]        o_sdc_c;
  logic [IMM_W-1:0]  o_sdc_imm;
  logic              o_sdc_imm_vld;
  logic [1:0]        o_sdc_dbg_state;

  // Handshakes: a beat transfers on a clock edge where i_sdc_enc_vld && o_sdc_enc_rdy;
  // an op transfers where o_sdc_op_vld && i_sdc_op_rdy. Neither rdy depends on the
  // matching vld, and o_sdc_op_vld never depends on i_sdc_op_rdy.
  modport slave (
    input  i_sdc_flush, i_sdc_enc, i_sdc_enc_vld, i_sdc_op_rdy,
    output o_sdc_enc_rdy, o_sdc_op_vld, o_sdc_opc, o_sdc_p, o_sdc_a, o_sdc_q,
           o_sdc_b, o_sdc_c, o_sdc_imm, o_sdc_imm_vld, o_sdc_dbg_state
  );

  modport master (
    output i_sdc_flush, i_sdc_enc, i_sdc_enc_vld, i_sdc_op_rdy,
    input  o_sdc_enc_rdy, o_sdc_op_vld, o_sdc_opc, o_sdc_p, o_sdc_a, o_sdc_q,
           o_sdc_b, o_sdc_c, o_sdc_imm, o_sdc_imm_vld, o_sdc_dbg_state
  );
endinterface

// File: rtl/idli_sdecode_m.sv
// Serial instruction decoder: LANE_W-bit beats, MSB first, into one decoded op record.
// Define IDLI_SDECODE_OVERLAP_EN to keep collecting the next op while one is held.
module idli_sdecode_m #(
  parameter int LANE_W = 4,
  parameter int IMM_W  = 16
) (
  input  logic              i_sdc_gck,
  input  logic              i_sdc_rst,
  idli_sdecode_m_if.slave   sdc
);

  localparam logic [1:0] ST_INSN = 2'd0;
  localparam logic [1:0] ST_IMM  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int INSN_BEATS = 16 / LANE_W;
  localparam int IMM_BEATS  = IMM_W / LANE_W;
  localparam int MAX_BEATS  = (INSN_BEATS > IMM_BEATS) ? INSN_BEATS : IMM_BEATS;
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);
  localparam int SR_W       = (IMM_W > 16) ? IMM_W : 16;

  if (!(LANE_W == 1 || LANE_W == 2 || LANE_W == 4 || LANE_W == 8 || LANE_W == 16)) begin : g_bad_lane
    $error("idli_sdecode_m: LANE_W must be 1, 2, 4, 8 or 16");
  end
  if ((IMM_W < LANE_W) || ((IMM_W % LANE_W) != 0)) begin : g_bad_imm
    $error("idli_sdecode_m: IMM_W must be a non-zero multiple of LANE_W");
  end

  typedef struct packed {
    logic [4:0]       opc;
    logic [1:0]       p;
    logic [2:0]       a;
    logic [1:0]       q;
    logic [2:0]       b;
    logic [2:0]       c;
    logic [IMM_W-1:0] imm;
    logic             imm_vld;
  } rec_t;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d, sr_shift;
  rec_t             out_q, out_d, dec_rec;
  logic             enc_rdy, op_vld, beat;
  logic             insn_last, imm_last, word_nop, word_imm;
  logic [15:0]      word;
  logic [IMM_W-1:0] imm_val;

  // The word/immediate is taken from the shift result so the final beat is included.
  always_comb begin
    sr_shift  = (sr_q << LANE_W) | SR_W'(sdc.i_sdc_enc);
    word      = sr_shift[15:0];
    imm_val   = sr_shift[IMM_W-1:0];
    word_nop  = (word[15:12] == 4'b0000) && !word[8];
    word_imm  = (word[2:0] == 3'b111);
    insn_last = (state_q == ST_INSN) && (cnt_q == CNT_W'(INSN_BEATS - 1));
    imm_last  = (state_q == ST_IMM)  && (cnt_q == CNT_W'(IMM_BEATS - 1));
    dec_rec         = '0;
    dec_rec.opc     = word[15:11];
    dec_rec.p       = (word[15:12] == 4'b0000) ? 2'b00 : word[10:9];
    dec_rec.a       = word[8:6];
    dec_rec.q       = word[7:6];
    dec_rec.b       = word[5:3];
    dec_rec.c       = word[2:0];
  end

  assign beat = sdc.i_sdc_enc_vld && enc_rdy;

`ifdef IDLI_SDECODE_OVERLAP_EN
  // Output slot (out_q/out_vld_q) is independent of the collector; HOLD here means a
  // completed op is parked in pend_q waiting for the output slot to free up.
  logic out_vld_q, out_vld_d;
  rec_t pend_q, pend_d;
  rec_t done_rec;
  logic done, slot_free;

  assign enc_rdy   = (state_q != ST_HOLD);
  assign op_vld    = out_vld_q;
  assign slot_free = !out_vld_q || sdc.i_sdc_op_rdy;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    out_d     = out_q;
    pend_d    = pend_q;
    out_vld_d = out_vld_q && !sdc.i_sdc_op_rdy;
    done      = 1'b0;
    done_rec  = pend_q;
    if (beat) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q + CNT_W'(1);
      if (insn_last) begin
        cnt_d = '0;
        if (!word_nop) begin
          if (word_imm) begin
            pend_d  = dec_rec;
            state_d = ST_IMM;
          end else begin
            done     = 1'b1;
            done_rec = dec_rec;
          end
        end
      end else if (imm_last) begin
        cnt_d            = '0;
        done             = 1'b1;
        done_rec.imm     = imm_val;
        done_rec.imm_vld = 1'b1;
      end
    end
    if ((state_q == ST_HOLD) && slot_free) begin
      out_d     = pend_q;
      out_vld_d = 1'b1;
      state_d   = ST_INSN;
    end
    if (done) begin
      if (slot_free) begin
        out_d     = done_rec;
        out_vld_d = 1'b1;
        state_d   = ST_INSN;
      end else begin
        pend_d  = done_rec;
        state_d = ST_HOLD;
      end
    end
    if (sdc.i_sdc_flush) begin
      state_d   = ST_INSN;
      cnt_d     = '0;
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_sdc_gck or posedge i_sdc_rst) begin
    if (i_sdc_rst) begin
      out_vld_q <= 1'b0;
      pend_q    <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      pend_q    <= pend_d;
    end
  end
`else
  // Fields are latched straight into the output record; HOLD is the only valid state.
  assign enc_rdy = (state_q != ST_HOLD);
  assign op_vld  = (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    out_d   = out_q;
    if (beat) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q + CNT_W'(1);
      if (insn_last) begin
        cnt_d = '0;
        if (!word_nop) begin
          out_d   = dec_rec;
          state_d = word_imm ? ST_IMM : ST_HOLD;
        end
      end else if (imm_last) begin
        cnt_d         = '0;
        out_d.imm     = imm_val;
        out_d.imm_vld = 1'b1;
        state_d       = ST_HOLD;
      end
    end
    if (op_vld && sdc.i_sdc_op_rdy) begin
      state_d = ST_INSN;
    end
    if (sdc.i_sdc_flush) begin
      state_d = ST_INSN;
      cnt_d   = '0;
    end
  end
`endif

  always_ff @(posedge i_sdc_gck or posedge i_sdc_rst) begin
    if (i_sdc_rst) begin
      state_q <= ST_INSN;
      cnt_q   <= '0;
      sr_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      out_q   <= out_d;
    end
  end

  assign sdc.o_sdc_enc_rdy   = enc_rdy;
  assign sdc.o_sdc_op_vld    = op_vld;
  assign sdc.o_sdc_opc       = out_q.opc;
  assign sdc.o_sdc_p         = out_q.p;
  assign sdc.o_sdc_a         = out_q.a;
  assign sdc.o_sdc_q         = out_q.q;
  assign sdc.o_sdc_b         = out_q.b;
  assign sdc.o_sdc_c         = out_q.c;
  assign sdc.o_sdc_imm       = out_q.imm;
  assign sdc.o_sdc_imm_vld   = out_q.imm_vld;
  assign sdc.o_sdc_dbg_state = state_q;

endmodule

// File: tb/tb_idli_sdecode_m.sv
// Bench for idli_sdecode_m: randomized and directed words, expected ops queued at issue
// and compared by an independent output monitor.
module tb_idli_sdecode_m;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  idli_sdecode_m_if #(.LANE_W(4), .IMM_W(16)) sif ();
  idli_sdecode_m_if #(.LANE_W(1), .IMM_W(16)) sif1 ();

  idli_sdecode_m #(.LANE_W(4), .IMM_W(16)) dut (
    .i_sdc_gck (clk),
    .i_sdc_rst (rst),
    .sdc       (sif.slave)
  );

  idli_sdecode_m #(.LANE_W(1), .IMM_W(16)) dut1 (
    .i_sdc_gck (clk),
    .i_sdc_rst (rst),
    .sdc       (sif1.slave)
  );

  logic [34:0] rec_now, rec1;
  assign rec_now = {sif.o_sdc_opc, sif.o_sdc_p, sif.o_sdc_a, sif.o_sdc_q, sif.o_sdc_b,
                    sif.o_sdc_c, sif.o_sdc_imm, sif.o_sdc_imm_vld};
  assign rec1    = {sif1.o_sdc_opc, sif1.o_sdc_p, sif1.o_sdc_a, sif1.o_sdc_q, sif1.o_sdc_b,
                    sif1.o_sdc_c, sif1.o_sdc_imm, sif1.o_sdc_imm_vld};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode from the field definitions, using plain integer arithmetic.
  function automatic logic [34:0] model_op(input logic [15:0] w, input logic [15:0] imm, input bit has);
    int wi, opc, p, a, q, b, c;
    logic [15:0] iv;
    wi  = int'(w);
    opc = wi / 2048;
    p   = ((wi / 4096) == 0) ? 0 : (wi / 512) % 4;
    a   = (wi / 64) % 8;
    q   = (wi / 64) % 4;
    b   = (wi / 8) % 8;
    c   = wi % 8;
    iv  = has ? imm : 16'h0000;
    return {opc[4:0], p[1:0], a[2:0], q[1:0], b[2:0], c[2:0], iv, has};
  endfunction

  task automatic put_beat(input logic [3:0] v);
    int n;
    n = 0;
    sif.i_sdc_enc     = v;
    sif.i_sdc_enc_vld = 1'b1;
    while (!sif.o_sdc_enc_rdy && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout enc_rdy stayed 0 for %0d cycles, required 1", n);
    end
    tick();
    sif.i_sdc_enc_vld = 1'b0;
  endtask

  task automatic send_nibbles(input logic [15:0] v, input int gap);
    for (int i = 3; i >= 0; i--) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) tick();
      put_beat(v[4*i +: 4]);
    end
  endtask

  task automatic issue(input logic [15:0] w, input logic [15:0] imm, input int gap);
    bit nop, has;
    nop = ((int'(w) / 4096) == 0) && (((int'(w) / 256) % 2) == 0);
    has = !nop && ((int'(w) % 8) == 7);
    if (!nop) exp_q.push_back(model_op(w, imm, has));
    send_nibbles(w, gap);
    if (has) send_nibbles(imm, gap);
  endtask

  // Consumer: op_rdy changes 2 time units after the edge, stable at the monitor sample.
  initial begin
    sif.i_sdc_op_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       sif.i_sdc_op_rdy = 1'b1;
        1:       sif.i_sdc_op_rdy = ($urandom_range(0, 3) != 0);
        default: sif.i_sdc_op_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every accepted op and checks held outputs stay stable.
  logic        prev_hold = 1'b0;
  logic        prev_flush = 1'b0;
  logic [34:0] prev_rec = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && !prev_flush) begin
        check("hold_vld", sif.o_sdc_op_vld, 1);
        check("hold_rec", rec_now, prev_rec);
      end
      if (sif.o_sdc_op_vld && sif.i_sdc_op_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_op actual=%0h expected none", rec_now);
        end else begin
          check("op_rec", rec_now, exp_q.pop_front());
        end
      end
      prev_hold  = sif.o_sdc_op_vld && !sif.i_sdc_op_rdy;
      prev_rec   = rec_now;
      prev_flush = sif.i_sdc_flush;
    end
  end

  initial begin
    logic [15:0] w, w1, im;
    int r, n;
    sif.i_sdc_flush    = 1'b0;
    sif.i_sdc_enc      = '0;
    sif.i_sdc_enc_vld  = 1'b0;
    sif1.i_sdc_flush   = 1'b0;
    sif1.i_sdc_enc     = '0;
    sif1.i_sdc_enc_vld = 1'b0;
    sif1.i_sdc_op_rdy  = 1'b1;

    #12;
    check("rst_op_vld", sif.o_sdc_op_vld, 0);
    check("rst_enc_rdy", sif.o_sdc_enc_rdy, 1);
    check("rst_rec", rec_now, 0);
    check("rst_state", sif.o_sdc_dbg_state, 0);
    check("rst_l1_vld", sif1.o_sdc_op_vld, 0);
    tick();
    rst = 1'b0;
    tick();

    issue(16'hC5A9, 16'h0000, 0);
    check("lat_plain", sif.o_sdc_op_vld, 1);
    tick();
    tick();

    exp_q.push_back(model_op(16'hC5AF, 16'h1234, 1'b1));
    send_nibbles(16'hC5AF, 0);
    check("imm_no_early", sif.o_sdc_op_vld, 0);
    send_nibbles(16'h1234, 0);
    check("lat_imm", sif.o_sdc_op_vld, 1);
    tick();
    tick();

    send_nibbles(16'h0000, 0);
    check("nop_none0", sif.o_sdc_op_vld, 0);
    tick();
    check("nop_none1", sif.o_sdc_op_vld, 0);
    issue(16'h0700, 16'h0000, 0);
    check("lat_0700", sif.o_sdc_op_vld, 1);
    tick();

    w1 = 16'hC5A9;
    for (int i = 15; i >= 0; i--) begin
      sif1.i_sdc_enc     = w1[i];
      sif1.i_sdc_enc_vld = 1'b1;
      n = 0;
      while (!sif1.o_sdc_enc_rdy && n < 100) begin
        tick();
        n++;
      end
      tick();
      sif1.i_sdc_enc_vld = 1'b0;
      if (i > 0) begin
        check("l1_no_early", sif1.o_sdc_op_vld, 0);
        tick();
      end
    end
    check("l1_lat", sif1.o_sdc_op_vld, 1);
    check("l1_rec", rec1, model_op(16'hC5A9, 16'h0000, 1'b0));
    tick();
    check("l1_clear", sif1.o_sdc_op_vld, 0);

    rdy_mode = 2;
    tick();
    issue(16'hC5A9, 16'h0000, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_op_vld", sif.o_sdc_op_vld, 1);
`ifndef IDLI_SDECODE_OVERLAP_EN
      check("hold_enc_rdy", sif.o_sdc_enc_rdy, 0);
`endif
    end
`ifdef IDLI_SDECODE_OVERLAP_EN
    issue(16'hC5A9, 16'h0000, 0);
    check("stage_full_rdy", sif.o_sdc_enc_rdy, 0);
    rdy_mode = 0;
    tick();
    check("b2b_vld", sif.o_sdc_op_vld, 1);
    tick();
    check("b2b_done", sif.o_sdc_op_vld, 0);
`else
    rdy_mode = 0;
    tick();
    check("release_vld", sif.o_sdc_op_vld, 0);
    check("release_rdy", sif.o_sdc_enc_rdy, 1);
`endif

    put_beat(4'hC);
    put_beat(4'h5);
    put_beat(4'hA);
    put_beat(4'hF);
    put_beat(4'h1);
    sif.i_sdc_enc     = 4'h2;
    sif.i_sdc_enc_vld = 1'b1;
    sif.i_sdc_flush   = 1'b1;
    tick();
    sif.i_sdc_flush   = 1'b0;
    sif.i_sdc_enc_vld = 1'b0;
    check("flush_vld", sif.o_sdc_op_vld, 0);
    check("flush_rdy", sif.o_sdc_enc_rdy, 1);
    issue(16'hC5A9, 16'h0000, 0);
    check("flush_next_lat", sif.o_sdc_op_vld, 1);
    tick();

    rdy_mode = 2;
    tick();
    send_nibbles(16'h1234, 0);
    check("fh_vld", sif.o_sdc_op_vld, 1);
    sif.i_sdc_flush = 1'b1;
    tick();
    sif.i_sdc_flush = 1'b0;
    check("fh_cleared", sif.o_sdc_op_vld, 0);

    send_nibbles(16'hC5A9, 0);
    check("rh_vld", sif.o_sdc_op_vld, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_vld", sif.o_sdc_op_vld, 0);
    check("async_rst_rdy", sif.o_sdc_enc_rdy, 1);
    check("async_rst_rec", rec_now, 0);
    tick();
    tick();
    rst = 1'b0;
    rdy_mode = 0;
    tick();
    issue(16'h9ABC, 16'h0000, 0);
    check("rst_next_lat", sif.o_sdc_op_vld, 1);
    tick();

    rdy_mode = 1;
    for (int k = 0; k < 60; k++) begin
      w  = 16'($urandom_range(0, 65535));
      im = 16'($urandom_range(0, 65535));
      r  = $urandom_range(0, 7);
      if (r == 0) begin
        w[15:12] = 4'h0;
        w[8]     = 1'b0;
      end else if (r <= 2) begin
        w[2:0] = 3'b111;
      end
      issue(w, im, 2);
    end

    rdy_mode = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("drain", exp_q.size(), 0);
    check("final_idle", sif.o_sdc_op_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idli_sdecode_m.md
Name: idli_sdecode_m

Overview:
Parametrised serial front-end decoder that supersedes the fixed 4b/cycle decoder. It accepts instruction bits LANE_W per beat, MSB first, and assembles the 16b instruction word. It extracts the opcode and operand fields, absorbs a trailing immediate into the same output record, drops NOPs, and presents one decoded op to execute under a valid/ready handshake with backpressure and flush.

Parameters:
LANE_W, 4, bits per input beat; legal values 1, 2, 4, 8, 16; elaboration error otherwise.
IMM_W, 16, trailing immediate width; must be a multiple of LANE_W.

Ports:
i_sdc_gck  in  1  clock
i_sdc_rst  in  1  asynchronous active-high reset
i_sdc_flush  in  1  synchronous discard of any partial or held op
i_sdc_enc  in  LANE_W  instruction/immediate beat, bit LANE_W-1 most significant
i_sdc_enc_vld  in  1  beat valid
o_sdc_enc_rdy  out  1  beat accepted when vld&rdy
o_sdc_op_vld  out  1  decoded op valid
i_sdc_op_rdy  in  1  consumer accepts op when vld&rdy
o_sdc_opc  out  5  word[15:11]
o_sdc_p  out  2  word[10:9]; forced 2'b00 (PT) when word[15:12]==4'b0000
o_sdc_a  out  3  word[8:6]
o_sdc_q  out  2  word[7:6]
o_sdc_b  out  3  word[5:3]
o_sdc_c  out  3  word[2:0]
o_sdc_imm  out  IMM_W  captured immediate; 0 when no immediate
o_sdc_imm_vld  out  1  op carries an immediate

Behaviour:
- Clock i_sdc_gck, single domain; reset i_sdc_rst asynchronous, active-high.
- Reset values: state INSN, beat count 0, o_sdc_op_vld=0, o_sdc_enc_rdy=1, all field outputs and o_sdc_imm 0, o_sdc_imm_vld=0.
- Shift rule on an accepted beat: sr <= {sr[W-LANE_W-1:0], i_sdc_enc}. W is 16 in INSN and IMM_W in IMM.
- Beat counter counts accepted beats and wraps to 0 at each phase end. INSN needs 16/LANE_W beats; IMM needs IMM_W/LANE_W beats.
- States:
  - INSN: rdy=1. On the final INSN beat the word is complete (assembled combinationally with the final beat):
    - NOP (word[15:12]==0000 and word[8]==0): discard, stay INSN, no output.
    - Else if word[2:0]==3'b111: latch the fields, go to IMM.
    - Else: latch the fields, imm=0, imm_vld=0, go to HOLD.
  - IMM: rdy=1. On the final IMM beat, o_sdc_imm <= assembled value, imm_vld <= 1, go to HOLD.
  - HOLD: o_sdc_op_vld=1, rdy=0. All outputs stay stable until accepted. On accept (vld&rdy), go to INSN and deassert op_vld the next cycle.
- Latency: op_vld rises the cycle after the final beat (instruction beat, or immediate beat if present) is accepted.
- A cycle with enc_vld=0 holds state and count; gaps are legal in any phase, including between the instruction and its immediate.
- Flush: next state INSN, count 0, op_vld 0 next cycle. A beat presented in the same cycle is discarded. Flush takes priority over accept.
- Reset mid-phase discards everything, identical to power-on.

Optional Feature:
IDLI_SDECODE_OVERLAP_EN:
- Defined: HOLD keeps rdy=1 and collection of the next word proceeds into a second staging register while the output is held.
  - If that word (and its immediate) completes before accept, rdy drops until accept. The staged op becomes valid the cycle after accept, so back-to-back ops can issue on consecutive accepts.
  - A NOP completing in staging is dropped silently.
  - Flush clears both held and staged ops.
- Undefined: rdy=0 throughout HOLD, as above.

Test Plan:
- LANE_W=4, beats C,5,A,9, op_rdy=1 -> op_vld one cycle after the 4th beat: opc=11000, p=10, a=110, q=10, b=101, c=001, imm_vld=0.
- LANE_W=4, beats C,5,A,F,1,2,3,4 -> single op: c=111, imm=16'h1234, imm_vld=1; no op_vld after beat 4.
- Word 0x0000 then 0x0700 -> first produces no op_vld; second emits opc=00000, p=00 (forced), a=100.
- LANE_W=1, word 0xC5A9 as 16 single-bit beats with enc_vld low every other cycle -> same fields as the first test, op_vld one cycle after the 16th beat.
- op_rdy held low 3 cycles with 0xC5A9 held -> outputs stable, enc_rdy=0 (macro off). With macro on, a second 0xC5A9 accepted during HOLD is emitted the cycle after the first accept.
- Flush asserted after 5 beats of C,5,A,F,1,2,... and async reset asserted in HOLD -> no op_vld, next word decodes cleanly. Reset forces op_vld=0 without waiting for a clock edge.
